spike_rx_window_counter: RTL

//  Receives the asynchronous cross-board spike line (spike_in1), synchronises and glitch-filters it,
//  and counts accepted spikes per sim_clk window. Sits directly downstream of the spike input pin and

---
 rtl/spike_rx_pkg.sv | 23 ++
 rtl/spike_rx_window_counter_filter.sv | 115 +++++++++++
 rtl/spike_rx_window_counter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spike_rx_pkg.sv
// spike_rx_pkg
//   Shared definitions for the spike receive path: filter state encodings,
//   default counter width and a saturating increment helper.
package spike_rx_pkg;

  localparam int CW_DEFAULT = 32;

  // Filter FSM state encodings (plain constants for legacy tool compatibility)
  typedef logic [1:0] filt_state_t;
  localparam filt_state_t S_LOW  = 2'd0;
  localparam filt_state_t S_RISE = 2'd1;
  localparam filt_state_t S_HIGH = 2'd2;
  localparam filt_state_t S_FALL = 2'd3;

  // Increment val, sticking at the all-ones value of a width-bit counter.
  // Callers zero-extend into 64 bits and truncate the result back.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/spike_rx_window_counter_filter.sv
// spike_edge_filter
//   Synchronises the asynchronous spike line and glitch-filters it: a spike is
//   accepted after MIN_HIGH consecutive high samples and the filter re-arms
//   only after MIN_LOW consecutive low samples.
// Ports
//   clk          in   clk1 domain clock
//   reset_global in   asynchronous active-high reset
//   clear        in   synchronous active-high clear
//   spike_in     in   raw asynchronous spike line
//   spike_pulse  out  registered one-cycle pulse per accepted spike
module spike_edge_filter
  import spike_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 4,
  parameter int MIN_LOW     = 4
) (
  input  logic clk,
  input  logic reset_global,
  input  logic clear,
  input  logic spike_in,
  output logic spike_pulse
);

  localparam int HW = $clog2(MIN_HIGH + 1);
  localparam int LW = $clog2(MIN_LOW + 1);
  localparam logic [HW-1:0] H_LAST = HW'(MIN_HIGH - 1);
  localparam logic [LW-1:0] L_LAST = LW'(MIN_LOW - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  filt_state_t            state_reg, state_next;
  logic [HW-1:0]          hcnt_reg, hcnt_next;
  logic [LW-1:0]          lcnt_reg, lcnt_next;
  logic                   pulse_reg, pulse_next;

  // Synchroniser carries no reset so it keeps flushing while reset is held
  always_ff @(posedge clk) begin
    sync_reg <= {sync_reg[SYNC_STAGES-2:0], spike_in};
  end

  assign s = sync_reg[SYNC_STAGES-1];

  always_comb begin
    state_next = state_reg;
    hcnt_next  = hcnt_reg;
    lcnt_next  = lcnt_reg;
    pulse_next = 1'b0;
    case (state_reg)
      S_LOW: begin
        if (s) begin
          if (MIN_HIGH == 1) begin
            state_next = S_HIGH;
            pulse_next = 1'b1;
          end else begin
            state_next = S_RISE;
            hcnt_next  = HW'(1);
          end
        end
      end
      S_RISE: begin
        if (!s) begin
          state_next = S_LOW;
        end else if (hcnt_reg == H_LAST) begin
          state_next = S_HIGH;
          pulse_next = 1'b1;
        end else begin
          hcnt_next = hcnt_reg + HW'(1);
        end
      end
      S_HIGH: begin
        if (!s) begin
          if (MIN_LOW == 1) begin
            state_next = S_LOW;
          end else begin
            state_next = S_FALL;
            lcnt_next  = LW'(1);
          end
        end
      end
      S_FALL: begin
        if (s) begin
          state_next = S_HIGH;
        end else if (lcnt_reg == L_LAST) begin
          state_next = S_LOW;
        end else begin
          lcnt_next = lcnt_reg + LW'(1);
        end
      end
      default: state_next = S_LOW;
    endcase
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      state_reg <= S_LOW;
      hcnt_reg  <= '0;
      lcnt_reg  <= '0;
      pulse_reg <= 1'b0;
    end else if (clear) begin
      state_reg <= S_LOW;
      hcnt_reg  <= '0;
      lcnt_reg  <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      hcnt_reg  <= hcnt_next;
      lcnt_reg  <= lcnt_next;
      pulse_reg <= pulse_next;
    end
  end

  assign spike_pulse = pulse_reg;

endmodule

// File: rtl/spike_rx_window_counter.sv
// spike_rx_window_counter
//   Counts filtered spikes per slow_clk window and measures the interval
//   between the two most recent spikes.
// Ports
//   clk          in   clk1, all logic in this domain
//   reset_global in   asynchronous active-high reset
//   clear        in   synchronous active-high clear (reset_sim level)
//   spike_in     in   asynchronous spike line
//   slow_clk     in   sim_clk level; rising edge closes a window
//   spike_pulse  out  one-cycle pulse per accepted spike
//   win_count    out  spikes in the last completed window
//   win_valid    out  one-cycle strobe when win_count updates
//   isi          out  clk cycles between the two most recent spikes
//   isi_valid    out  two spikes seen since reset/clear
//   overflow     out  sticky saturation flag
module spike_rx_window_counter
  import spike_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 4,
  parameter int MIN_LOW     = 4,
  parameter int CW          = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_global,
  input  logic          clear,
  input  logic          spike_in,
  input  logic          slow_clk,
  output logic          spike_pulse,
  output logic [CW-1:0] win_count,
  output logic          win_valid,
  output logic [CW-1:0] isi,
  output logic          isi_valid,
  output logic          overflow
);

  localparam logic [CW-1:0] MAX_VAL = '1;

  logic [1:0]    slow_sync_reg;
  logic          slow_prev_reg;
  logic          win_tick;
  logic [CW-1:0] acc_reg, acc_next;
  logic [CW-1:0] win_count_reg, win_count_next;
  logic          win_valid_reg, win_valid_next;
  logic [CW-1:0] icnt_reg, icnt_next;
  logic [CW-1:0] isi_reg, isi_next;
  logic          isi_valid_reg, isi_valid_next;
  logic          have_prev_reg, have_prev_next;
  logic          overflow_reg, overflow_next;

  spike_edge_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_HIGH    (MIN_HIGH),
    .MIN_LOW     (MIN_LOW)
  ) u_filter (
    .clk          (clk),
    .reset_global (reset_global),
    .clear        (clear),
    .spike_in     (spike_in),
    .spike_pulse  (spike_pulse)
  );

  // Unreset edge detector: it keeps tracking slow_clk during reset/clear, so
  // the previous-value flop already holds the current level on release and a
  // high slow_clk does not produce a spurious window.
  always_ff @(posedge clk) begin
    slow_sync_reg <= {slow_sync_reg[0], slow_clk};
    slow_prev_reg <= slow_sync_reg[1];
  end

  assign win_tick = slow_sync_reg[1] & ~slow_prev_reg;

  always_comb begin
    acc_next       = acc_reg;
    win_count_next = win_count_reg;
    win_valid_next = win_tick;
    icnt_next      = icnt_reg;
    isi_next       = isi_reg;
    isi_valid_next = isi_valid_reg;
    have_prev_next = have_prev_reg;
    overflow_next  = overflow_reg;

    // A spike coincident with the tick belongs to the new window
    if (win_tick) begin
      win_count_next = acc_reg;
      acc_next       = {{(CW-1){1'b0}}, spike_pulse};
    end else if (spike_pulse) begin
      acc_next = CW'(sat_inc(64'(acc_reg), CW));
      if (acc_reg == MAX_VAL) overflow_next = 1'b1;
    end

    // isi is icnt+1 because icnt restarts at 0 in the cycle after a spike
    if (spike_pulse) begin
      if (have_prev_reg) begin
        isi_next       = CW'(sat_inc(64'(icnt_reg), CW));
        isi_valid_next = 1'b1;
      end
      icnt_next      = '0;
      have_prev_next = 1'b1;
    end else begin
      icnt_next = CW'(sat_inc(64'(icnt_reg), CW));
      if (icnt_reg == MAX_VAL) overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      acc_reg       <= '0;
      win_count_reg <= '0;
      win_valid_reg <= 1'b0;
      icnt_reg      <= '0;
      isi_reg       <= '0;
      isi_valid_reg <= 1'b0;
      have_prev_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (clear) begin
      acc_reg       <= '0;
      win_count_reg <= '0;
      win_valid_reg <= 1'b0;
      icnt_reg      <= '0;
      isi_reg       <= '0;
      isi_valid_reg <= 1'b0;
      have_prev_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      win_count_reg <= win_count_next;
      win_valid_reg <= win_valid_next;
      icnt_reg      <= icnt_next;
      isi_reg       <= isi_next;
      isi_valid_reg <= isi_valid_next;
      have_prev_reg <= have_prev_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign win_count = win_count_reg;
  assign win_valid = win_valid_reg;
  assign isi       = isi_reg;
  assign isi_valid = isi_valid_reg;
  assign overflow  = overflow_reg;

endmodule
